// File: rtl/grid_placer_if.sv
`default_nettype none
// ============================================================================
//  Module      : grid_placer_if
//  Description : Command port and pixel stream bundle of the grid placer.
//                The master side is the placement engine; the slave side is
//                the command source and framebuffer writer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface grid_placer_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 9
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [1:0]          cmd_dir;
  logic                pix_valid;
  logic                pix_ready;
  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;
  logic [COLOUR_W-1:0] pix_colour;

  // Engine side: consumes commands, produces pixels.
  modport master (
    input  cmd_valid, cmd_op, cmd_dir, pix_ready,
    output cmd_ready, pix_valid, pix_x, pix_y, pix_colour
  );

  // Environment side: issues commands, sinks pixels.
  modport slave (
    output cmd_valid, cmd_op, cmd_dir, pix_ready,
    input  cmd_ready, pix_valid, pix_x, pix_y, pix_colour
  );
endinterface
`default_nettype wire

// File: rtl/grid_placer.sv
`default_nettype none
// ============================================================================
//  Module      : grid_placer
//  Description : Grid cursor and tower-placement engine. Accepts MOVE, PLACE,
//                REMOVE and REDRAW commands, keeps the cursor cell and an
//                occupancy bitmap, and streams the affected cell(s) as raster
//                pixels with valid/ready backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module grid_placer #(
  parameter int                 GRID_COLS     = 8,
  parameter int                 GRID_ROWS     = 6,
  parameter int                 CELL          = 20,
  parameter int                 X_OFF         = 0,
  parameter int                 Y_OFF         = 0,
  parameter int                 X_W           = 8,
  parameter int                 Y_W           = 7,
  parameter int                 COLOUR_W      = 9,
  parameter logic [COLOUR_W-1:0] BG_COLOUR     = 9'h000,
  parameter logic [COLOUR_W-1:0] TOWER_COLOUR  = 9'h1C0,
  parameter logic [COLOUR_W-1:0] CURSOR_COLOUR = 9'h1FF
) (
  input  logic                                         clk,
  input  logic                                         reset,
  grid_placer_if.master                                bus,
  output logic                                         done,
  output logic                                         rejected,
  output logic [$clog2(GRID_COLS)-1:0]                 cur_col,
  output logic [$clog2(GRID_ROWS)-1:0]                 cur_row,
  output logic                                         occupied_here,
  output logic [$clog2(GRID_COLS*GRID_ROWS+1)-1:0]     tower_count
);

  localparam int COL_W = $clog2(GRID_COLS);
  localparam int ROW_W = $clog2(GRID_ROWS);
  localparam int CELLS = GRID_COLS * GRID_ROWS;
  localparam int IDX_W = $clog2(CELLS);
  localparam int TC_W  = $clog2(CELLS + 1);
  localparam int L_W   = $clog2(CELL);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(GRID_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(GRID_ROWS - 1);
  localparam logic [L_W-1:0]   L_MAX   = L_W'(CELL - 1);

  localparam logic [1:0] OP_MOVE   = 2'd0;
  localparam logic [1:0] OP_PLACE  = 2'd1;
  localparam logic [1:0] OP_REMOVE = 2'd2;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ERASE  = 3'd1,
    ST_CURSOR = 3'd2,
    ST_REJECT = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CELLS-1:0]  occ_q, occ_d;
  logic [TC_W-1:0]   tc_q, tc_d;
  logic [L_W-1:0]    lx_q, lx_d;
  logic [L_W-1:0]    ly_q, ly_d;
  logic [1:0]        dir_q, dir_d;
  logic              rej_q, rej_d;

  logic              w_ready;
  logic              w_accept;
  logic              w_pix_valid;
  logic              w_xfer;
  logic              w_last;
  logic              w_border;
  logic              w_occ_here;
  logic [IDX_W-1:0]  w_idx;
  logic [COL_W-1:0]  w_next_col;
  logic [ROW_W-1:0]  w_next_row;

  // A new command may be taken while idle and in the done cycle, so
  // back-to-back commands lose no cycle.
  assign w_ready     = (state_q == ST_IDLE) || (state_q == ST_FINISH);
  assign w_accept    = bus.cmd_valid && w_ready;
  assign w_pix_valid = (state_q == ST_ERASE) || (state_q == ST_CURSOR);
  assign w_xfer      = w_pix_valid && bus.pix_ready;
  assign w_last      = (lx_q == L_MAX) && (ly_q == L_MAX);
  assign w_border    = (lx_q == '0) || (lx_q == L_MAX) ||
                       (ly_q == '0) || (ly_q == L_MAX);
  assign w_idx       = IDX_W'(int'(row_q) * GRID_COLS + int'(col_q));
  assign w_occ_here  = occ_q[w_idx];

  // Wrap-around neighbour of the cursor in the latched move direction.
  always_comb begin
    w_next_col = col_q;
    w_next_row = row_q;
    case (dir_q)
      DIR_RIGHT: w_next_col = (col_q == COL_MAX) ? '0 : col_q + COL_W'(1);
      DIR_LEFT:  w_next_col = (col_q == '0) ? COL_MAX : col_q - COL_W'(1);
      DIR_DOWN:  w_next_row = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
      default:   w_next_row = (row_q == '0) ? ROW_MAX : row_q - ROW_W'(1);
    endcase
  end

  // Next-state logic: command decode, raster walk and pass sequencing.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    occ_d   = occ_q;
    tc_d    = tc_q;
    lx_d    = lx_q;
    ly_d    = ly_q;
    dir_d   = dir_q;
    rej_d   = rej_q;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        state_d = ST_IDLE;
        if (w_accept) begin
          lx_d  = '0;
          ly_d  = '0;
          rej_d = 1'b0;
          case (bus.cmd_op)
            OP_MOVE: begin
              dir_d   = bus.cmd_dir;
              state_d = ST_ERASE;
            end
            OP_PLACE: begin
              if (w_occ_here) begin
                rej_d   = 1'b1;
                state_d = ST_REJECT;
              end else begin
                occ_d[w_idx] = 1'b1;
                tc_d         = tc_q + TC_W'(1);
                state_d      = ST_CURSOR;
              end
            end
            OP_REMOVE: begin
              if (!w_occ_here) begin
                rej_d   = 1'b1;
                state_d = ST_REJECT;
              end else begin
                occ_d[w_idx] = 1'b0;
                tc_d         = tc_q - TC_W'(1);
                state_d      = ST_CURSOR;
              end
            end
            default: state_d = ST_CURSOR;
          endcase
        end
      end

      ST_ERASE, ST_CURSOR: begin
        if (w_xfer) begin
          if (w_last) begin
            lx_d = '0;
            ly_d = '0;
            if (state_q == ST_ERASE) begin
              // Old cell is cleared; the cursor steps before its redraw.
              col_d   = w_next_col;
              row_d   = w_next_row;
              state_d = ST_CURSOR;
            end else begin
              state_d = ST_FINISH;
            end
          end else if (lx_q == L_MAX) begin
            lx_d = '0;
            ly_d = ly_q + L_W'(1);
          end else begin
            lx_d = lx_q + L_W'(1);
          end
        end
      end

      ST_REJECT: state_d = ST_FINISH;

      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      occ_q   <= '0;
      tc_q    <= '0;
      lx_q    <= '0;
      ly_q    <= '0;
      dir_q   <= '0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      occ_q   <= occ_d;
      tc_q    <= tc_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      dir_q   <= dir_d;
      rej_q   <= rej_d;
    end
  end

  // Pixel outputs are pure functions of registered state, so they hold
  // still for as long as the sink stalls; they read zero when not valid.
  always_comb begin
    bus.pix_x      = '0;
    bus.pix_y      = '0;
    bus.pix_colour = '0;
    if (w_pix_valid) begin
      bus.pix_x = X_W'(X_OFF + int'(col_q) * CELL + int'(lx_q));
      bus.pix_y = Y_W'(Y_OFF + int'(row_q) * CELL + int'(ly_q));
      if ((state_q == ST_CURSOR) && w_border) begin
        bus.pix_colour = CURSOR_COLOUR;
      end else if (w_occ_here) begin
        bus.pix_colour = TOWER_COLOUR;
      end else begin
        bus.pix_colour = BG_COLOUR;
      end
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.pix_valid = w_pix_valid;
  assign done          = (state_q == ST_FINISH);
  assign rejected      = (state_q == ST_FINISH) && rej_q;
  assign cur_col       = col_q;
  assign cur_row       = row_q;
  assign occupied_here = w_occ_here;
  assign tower_count   = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_placer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grid_placer
//  Description : Self-checking bench for grid_placer. Commands come from a
//                vector table; expected pixels are pushed to a scoreboard
//                queue by a reference model and popped as the DUT emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_placer;

  localparam int COLS  = 8;
  localparam int ROWS  = 6;
  localparam int CELL  = 20;
  localparam int X_OFF = 0;
  localparam int Y_OFF = 0;

  localparam int OP_MOVE = 0, OP_PLACE = 1, OP_REMOVE = 2, OP_REDRAW = 3;
  localparam int D_R = 0, D_L = 1, D_D = 2, D_U = 3;

  localparam int C_BG = 'h000, C_TOWER = 'h1C0, C_CURSOR = 'h1FF;

  typedef struct {
    int op; int dir;
    int col; int row; int cnt; int occ; int rej; int lat;
  } vec_t;

  typedef struct { int x; int y; int c; } pix_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       done, rejected, occupied_here;
  logic [2:0] cur_col, cur_row;
  logic [5:0] tower_count;

  grid_placer_if #(.X_W(8), .Y_W(7), .COLOUR_W(9)) bus ();

  grid_placer dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.master),
    .done          (done),
    .rejected      (rejected),
    .cur_col       (cur_col),
    .cur_row       (cur_row),
    .occupied_here (occupied_here),
    .tower_count   (tower_count)
  );

  always #5 clk = ~clk;

  pix_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   rdy_mode = 0;
  int   cyc = 0;
  int   m_col = 0;
  int   m_row = 0;
  bit   m_occ [COLS*ROWS];
  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference rendering of one cell pass.
  task automatic push_pass(input int col, input int row, input bit cursor, input bit occ);
    pix_t p;
    for (int y = 0; y < CELL; y++) begin
      for (int x = 0; x < CELL; x++) begin
        p.x = X_OFF + col * CELL + x;
        p.y = Y_OFF + row * CELL + y;
        if (cursor && (x == 0 || x == CELL - 1 || y == 0 || y == CELL - 1)) p.c = C_CURSOR;
        else if (occ) p.c = C_TOWER;
        else p.c = C_BG;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic model_apply(input int op, input int dir);
    int i;
    i = m_row * COLS + m_col;
    case (op)
      OP_MOVE: begin
        push_pass(m_col, m_row, 1'b0, m_occ[i]);
        case (dir)
          D_R:     m_col = (m_col + 1) % COLS;
          D_L:     m_col = (m_col + COLS - 1) % COLS;
          D_D:     m_row = (m_row + 1) % ROWS;
          default: m_row = (m_row + ROWS - 1) % ROWS;
        endcase
        push_pass(m_col, m_row, 1'b1, m_occ[m_row * COLS + m_col]);
      end
      OP_PLACE: if (!m_occ[i]) begin
        m_occ[i] = 1'b1;
        push_pass(m_col, m_row, 1'b1, 1'b1);
      end
      OP_REMOVE: if (m_occ[i]) begin
        m_occ[i] = 1'b0;
        push_pass(m_col, m_row, 1'b1, 1'b0);
      end
      default: push_pass(m_col, m_row, 1'b1, m_occ[i]);
    endcase
  endtask

  // Issues one command starting at a negedge, returns at the negedge of done.
  task automatic do_cmd(input vec_t v, input string tag);
    int guard;
    int lat;
    bit seen;
    model_apply(v.op, v.dir);
    bus.cmd_op    = 2'(v.op);
    bus.cmd_dir   = (v.op == OP_MOVE) ? 2'(v.dir) : 2'($urandom_range(0, 3));
    bus.cmd_valid = 1'b1;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " cmd_ready_at_offer"}, int'(bus.cmd_ready), 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 4000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, " cmd_ready_busy"}, int'(bus.cmd_ready), 0);
      if (done) seen = 1'b1;
    end
    chk({tag, " done_seen"}, int'(seen), 1);
    if (v.lat != 0) chk({tag, " latency"}, lat, v.lat);
    chk({tag, " rejected"},      int'(rejected), v.rej);
    chk({tag, " pixels_left"},   exp_q.size(), 0);
    chk({tag, " cur_col"},       int'(cur_col), v.col);
    chk({tag, " cur_row"},       int'(cur_row), v.row);
    chk({tag, " tower_count"},   int'(tower_count), v.cnt);
    chk({tag, " occupied_here"}, int'(occupied_here), v.occ);
  endtask

  // Sink readiness: always ready, or the 1,0,0,1 stall pattern.
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rdy_mode == 1) bus.pix_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else bus.pix_ready = 1'b1;
    end
  end

  // Scoreboard consumer plus hold-during-stall check.
  initial begin
    pix_t        p;
    logic [24:0] held;
    bit          stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_hold", int'({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_colour}), int'(held));
        end
        stall = bus.pix_valid && !bus.pix_ready;
        held  = {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_colour};
        if (bus.pix_valid && bus.pix_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_pixel: got (%0d,%0d,%h) expected none",
                     bus.pix_x, bus.pix_y, bus.pix_colour);
          end else begin
            p = exp_q.pop_front();
            if (int'(bus.pix_x) != p.x || int'(bus.pix_y) != p.y || int'(bus.pix_colour) != p.c) begin
              bad++;
              $display("FAIL pixel: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                       bus.pix_x, bus.pix_y, bus.pix_colour, p.x, p.y, p.c);
            end
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    int   guard;
    int   done_cnt;
    int   valid_cnt;

    vecs[0]  = '{OP_REDRAW, 0,   0, 0, 0, 0, 0, 401};
    vecs[1]  = '{OP_PLACE,  0,   0, 0, 1, 1, 0, 401};
    vecs[2]  = '{OP_PLACE,  0,   0, 0, 1, 1, 1, 2};
    vecs[3]  = '{OP_MOVE,   D_L, 7, 0, 1, 0, 0, 801};
    vecs[4]  = '{OP_MOVE,   D_U, 7, 5, 1, 0, 0, 801};
    vecs[5]  = '{OP_MOVE,   D_D, 7, 0, 1, 0, 0, 801};
    vecs[6]  = '{OP_MOVE,   D_R, 0, 0, 1, 1, 0, 801};
    vecs[7]  = '{OP_REMOVE, 0,   0, 0, 0, 0, 0, 401};
    vecs[8]  = '{OP_REMOVE, 0,   0, 0, 0, 0, 1, 2};
    vecs[9]  = '{OP_MOVE,   D_D, 0, 1, 0, 0, 0, 801};
    vecs[10] = '{OP_PLACE,  0,   0, 1, 1, 1, 0, 401};
    vecs[11] = '{OP_MOVE,   D_R, 1, 1, 1, 0, 0, 801};

    foreach (m_occ[i]) m_occ[i] = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_dir   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset cmd_ready",   int'(bus.cmd_ready), 1);
    chk("reset pix_valid",   int'(bus.pix_valid), 0);
    chk("reset done",        int'(done), 0);
    chk("reset rejected",    int'(rejected), 0);
    chk("reset pix_xy_col",  int'({bus.pix_x, bus.pix_y, bus.pix_colour}), 0);
    chk("reset cursor",      int'({cur_col, cur_row}), 0);
    chk("reset tower_count", int'(tower_count), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // Stalling sink during a redraw of the cursor cell (1,1).
    rdy_mode = 1;
    v = '{OP_REDRAW, 0, 1, 1, 1, 0, 0, 0};
    do_cmd(v, "stall");
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of a MOVE, after 200 pixel transfers.
    model_apply(OP_MOVE, D_D);
    bus.cmd_op    = 2'(OP_MOVE);
    bus.cmd_dir   = 2'(D_D);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    n = 0;
    guard = 0;
    while (n < 200 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (bus.pix_valid && bus.pix_ready) n++;
    end
    chk("midreset reached_200", n, 200);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    chk("midreset pix_valid",   int'(bus.pix_valid), 0);
    chk("midreset cursor",      int'({cur_col, cur_row}), 0);
    chk("midreset tower_count", int'(tower_count), 0);
    chk("midreset done",        int'(done), 0);
    reset = 1'b0;
    m_col = 0;
    m_row = 0;
    foreach (m_occ[i]) m_occ[i] = 1'b0;
    done_cnt  = 0;
    valid_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (bus.pix_valid) valid_cnt++;
    end
    chk("midreset no_done",   done_cnt, 0);
    chk("midreset no_pixels", valid_cnt, 0);

    v = '{OP_REDRAW, 0, 0, 0, 0, 0, 0, 401};
    do_cmd(v, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
